// File: rtl/ps2_morse_keyer.sv
// ps2_morse_keyer
// Turns PS/2 Set-2 scancodes into keyed Morse. Break (0xF0) and extended
// (0xE0) prefixes are filtered out. A-Z, 0-9 and space are translated and
// queued in a DEPTH-entry FIFO. A timing FSM keys the queued patterns out on
// morse_out, using UNIT_CYCLES clocks per dot. tone_out is a square wave
// gated by the mark.
//
// Ports
//   clk                    system clock
//   rst_n                  asynchronous active-low reset
//   ps2_received_data      scancode byte
//   ps2_received_data_strb one-cycle strobe, data valid this cycle
//   enable                 allows a new character to start
//   tone_en                enables tone_out
//   morse_out              keyed level, 1 = mark
//   tone_out               square wave (toggles every TONE_DIV clocks) during a mark
//   busy                   FSM not idle or FIFO not empty
//   fifo_full              FIFO level == DEPTH
//   overflow               sticky, a character was dropped on a full FIFO
//   fifo_level             current FIFO occupancy
module ps2_morse_keyer #(
    parameter int DEPTH       = 16,
    parameter int UNIT_CYCLES = 1200000,
    parameter int TONE_DIV    = 6000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               ps2_received_data,
    input  logic                     ps2_received_data_strb,
    input  logic                     enable,
    input  logic                     tone_en,
    output logic                     morse_out,
    output logic                     tone_out,
    output logic                     busy,
    output logic                     fifo_full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(4 * UNIT_CYCLES + 1);
    localparam int TW = $clog2(TONE_DIV + 1);

    localparam logic [CW-1:0] C_DOT  = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] C_DASH = CW'(3 * UNIT_CYCLES - 1);
    // The IDLE cycle that pops a space already counts as the first cycle of
    // the word gap. A space therefore adds exactly 4 units between marks,
    // and only the one idle cycle per character remains as overhead.
    localparam logic [CW-1:0] C_WORD = CW'(4 * UNIT_CYCLES - 2);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MARK     = 3'd1;
    localparam logic [2:0] S_GAP_ELEM = 3'd2;
    localparam logic [2:0] S_GAP_CHAR = 3'd3;
    localparam logic [2:0] S_GAP_WORD = 3'd4;

    // Set-2 scancode -> {valid, len[2:0], elem[4:0]}. Elements are
    // left-aligned in elem, so the first element sits in elem[4]. 1 = dash.
    function automatic logic [8:0] f_xlate(input logic [7:0] b);
        logic [8:0] v;
        v = '0;
        case (b)
            8'h1C: v = {1'b1, 3'd2, 5'b01000}; // A
            8'h32: v = {1'b1, 3'd4, 5'b10000}; // B
            8'h21: v = {1'b1, 3'd4, 5'b10100}; // C
            8'h23: v = {1'b1, 3'd3, 5'b10000}; // D
            8'h24: v = {1'b1, 3'd1, 5'b00000}; // E
            8'h2B: v = {1'b1, 3'd4, 5'b00100}; // F
            8'h34: v = {1'b1, 3'd3, 5'b11000}; // G
            8'h33: v = {1'b1, 3'd4, 5'b00000}; // H
            8'h43: v = {1'b1, 3'd2, 5'b00000}; // I
            8'h3B: v = {1'b1, 3'd4, 5'b01110}; // J
            8'h42: v = {1'b1, 3'd3, 5'b10100}; // K
            8'h4B: v = {1'b1, 3'd4, 5'b01000}; // L
            8'h3A: v = {1'b1, 3'd2, 5'b11000}; // M
            8'h31: v = {1'b1, 3'd2, 5'b10000}; // N
            8'h44: v = {1'b1, 3'd3, 5'b11100}; // O
            8'h4D: v = {1'b1, 3'd4, 5'b01100}; // P
            8'h15: v = {1'b1, 3'd4, 5'b11010}; // Q
            8'h2D: v = {1'b1, 3'd3, 5'b01000}; // R
            8'h1B: v = {1'b1, 3'd3, 5'b00000}; // S
            8'h2C: v = {1'b1, 3'd1, 5'b10000}; // T
            8'h3C: v = {1'b1, 3'd3, 5'b00100}; // U
            8'h2A: v = {1'b1, 3'd4, 5'b00010}; // V
            8'h1D: v = {1'b1, 3'd3, 5'b01100}; // W
            8'h22: v = {1'b1, 3'd4, 5'b10010}; // X
            8'h35: v = {1'b1, 3'd4, 5'b10110}; // Y
            8'h1A: v = {1'b1, 3'd4, 5'b11000}; // Z
            8'h45: v = {1'b1, 3'd5, 5'b11111}; // 0
            8'h16: v = {1'b1, 3'd5, 5'b01111}; // 1
            8'h1E: v = {1'b1, 3'd5, 5'b00111}; // 2
            8'h26: v = {1'b1, 3'd5, 5'b00011}; // 3
            8'h25: v = {1'b1, 3'd5, 5'b00001}; // 4
            8'h2E: v = {1'b1, 3'd5, 5'b00000}; // 5
            8'h36: v = {1'b1, 3'd5, 5'b10000}; // 6
            8'h3D: v = {1'b1, 3'd5, 5'b11000}; // 7
            8'h3E: v = {1'b1, 3'd5, 5'b11100}; // 8
            8'h46: v = {1'b1, 3'd5, 5'b11110}; // 9
            8'h29: v = {1'b1, 3'd0, 5'b00000}; // space -> word gap
            default: v = '0;
        endcase
        return v;
    endfunction

    logic          r_brk;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [LW-1:0] r_level;
    logic          r_ovf;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_elem;
    logic [2:0]    r_left;
    logic [TW-1:0] r_tdiv;
    logic          r_tone;

    logic [8:0]    w_xl;
    logic          w_push, w_full, w_wr, w_pop, w_mark;
    logic [7:0]    w_head;

    assign w_xl   = f_xlate(ps2_received_data);
    // 0xF0/0xE0 are not in the table, so they never reach the FIFO.
    assign w_push = ps2_received_data_strb && !r_brk && w_xl[8];
    assign w_full = (r_level == LW'(DEPTH));
    // A full FIFO refuses the write even if a pop frees a slot this cycle.
    assign w_wr   = w_push && !w_full;
    assign w_pop  = (r_state == S_IDLE) && enable && (r_level != '0);
    assign w_head = r_mem[r_rp];
    assign w_mark = (r_state == S_MARK);

    // Break flag: the byte after 0xF0 is swallowed. 0xE0 leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_brk <= 1'b0;
        end else if (ps2_received_data_strb) begin
            if (r_brk)
                r_brk <= 1'b0;
            else if (ps2_received_data == 8'hF0)
                r_brk <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wp] <= w_xl[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr)
                r_wp <= r_wp + AW'(1);
            if (w_pop)
                r_rp <= r_rp + AW'(1);
            r_level <= r_level + LW'(w_wr) - LW'(w_pop);
            if (w_push && w_full)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_elem  <= '0;
            r_left  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        if (w_head[7:5] != 3'd0) begin
                            r_state <= S_MARK;
                            r_cnt   <= w_head[4] ? C_DASH : C_DOT;
                            r_elem  <= {w_head[3:0], 1'b0};
                            r_left  <= w_head[7:5] - 3'd1;
                        end else begin
                            r_state <= S_GAP_WORD;
                            r_cnt   <= C_WORD;
                        end
                    end
                end
                S_MARK: begin
                    if (r_cnt == '0) begin
                        if (r_left != 3'd0) begin
                            r_state <= S_GAP_ELEM;
                            r_cnt   <= C_DOT;
                        end else begin
                            r_state <= S_GAP_CHAR;
                            r_cnt   <= C_DASH;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_GAP_ELEM: begin
                    if (r_cnt == '0) begin
                        r_state <= S_MARK;
                        r_cnt   <= r_elem[4] ? C_DASH : C_DOT;
                        r_elem  <= {r_elem[3:0], 1'b0};
                        r_left  <= r_left - 3'd1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_GAP_CHAR, S_GAP_WORD: begin
                    if (r_cnt == '0)
                        r_state <= S_IDLE;
                    else
                        r_cnt <= r_cnt - CW'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tone divider runs only while a toned mark is active. It is cleared
    // otherwise, so every mark starts with the tone low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tdiv <= '0;
            r_tone <= 1'b0;
        end else if (w_mark && tone_en) begin
            if (r_tdiv == TW'(TONE_DIV - 1)) begin
                r_tdiv <= '0;
                r_tone <= ~r_tone;
            end else begin
                r_tdiv <= r_tdiv + TW'(1);
            end
        end else begin
            r_tdiv <= '0;
            r_tone <= 1'b0;
        end
    end

    assign morse_out  = w_mark;
    assign tone_out   = r_tone && w_mark && tone_en;
    assign busy       = (r_state != S_IDLE) || (r_level != '0);
    assign fifo_full  = w_full;
    assign overflow   = r_ovf;
    assign fifo_level = r_level;

endmodule

// File: doc/ps2_morse_keyer.md
Name: ps2_morse_keyer

Overview:
- Parametrised successor to the single-output PS/2-to-Morse data path.
- Input: PS/2 Set-2 scancode bytes with a one-cycle strobe.
- Filters out break/extended prefixes and translates A-Z, 0-9 and space into Morse patterns.
- Queues the patterns in a DEPTH-entry FIFO and keys them out with programmable unit timing, an optional gated tone output and status flags.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, at least 2.
- UNIT_CYCLES, 1200000, clock cycles per Morse time unit (dot length); at least 1.
- TONE_DIV, 6000, tone half-period in clock cycles; at least 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ps2_received_data  in  8  scancode byte from the PS/2 controller.
- ps2_received_data_strb  in  1  one-cycle pulse; ps2_received_data is valid in this cycle.
- enable  in  1  allows new characters to start transmitting.
- tone_en  in  1  enables tone_out.
- morse_out  out  1  keyed Morse level (1 = mark).
- tone_out  out  1  square wave gated by the mark.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is not empty.
- fifo_full  out  1  high when the FIFO level equals DEPTH.
- overflow  out  1  sticky; set when a valid character is dropped because the FIFO is full.
- fifo_level  out  clog2(DEPTH)+1  current number of FIFO entries.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state: all outputs 0, FIFO empty, break flag 0, FSM in IDLE, all counters 0. A reset during a mark drops morse_out and tone_out immediately.
- Prefix filter, per strobe:
  - 0xF0 sets the break flag; the byte is discarded.
  - A byte arriving while the break flag is set is discarded and clears the flag.
  - 0xE0 is discarded and leaves the break flag unchanged.
- Translation: remaining bytes are mapped through the standard Set-2 table. Letters and digits become an 8-bit entry: {len[2:0], elem[4:0]}, elements MSB-first, 1 = dash. Space (0x29) becomes len = 0, meaning word gap. Unmapped bytes are dropped with no flag.
- FIFO write: registered, so a strobe in cycle n writes and updates fifo_level in cycle n+1.
- Full FIFO: a write is dropped and overflow is set if the FIFO is full at the write cycle, even if a pop happens in the same cycle.
- Simultaneous write and pop when not full: both occur and the level is unchanged.
- FSM states: IDLE, MARK, GAP_ELEM, GAP_CHAR, GAP_WORD.
  - IDLE: when enable = 1 and the FIFO is not empty, pop and latch the entry. Then go to MARK if len > 0, else to GAP_WORD.
  - MARK: morse_out = 1 from the cycle after the pop, or after the preceding gap. Lasts exactly UNIT_CYCLES (dot) or 3*UNIT_CYCLES (dash).
  - After MARK: if elements remain, go to GAP_ELEM for UNIT_CYCLES; otherwise go to GAP_CHAR for 3*UNIT_CYCLES, then IDLE.
  - GAP_WORD: 4*UNIT_CYCLES, then IDLE. Together with the preceding character gap this gives the standard 7-unit word gap.
- Enable: dropping enable mid-character does not abort; the current character and its gap complete, then the FSM holds in IDLE.
- Back-to-back characters: the next pop occurs in the IDLE cycle that follows GAP_CHAR. Each character therefore costs one extra idle cycle; this is accepted.
- Timing counter: counts down from units*UNIT_CYCLES-1 and is reloaded on each state change.
- Tone: when tone_en = 1 and morse_out = 1, tone_out toggles every TONE_DIV cycles, starting at 0 at the beginning of each mark. Otherwise tone_out = 0 and the tone divider is held at 0.

Test Plan:
- Common setup: DEPTH=4, UNIT_CYCLES=4, TONE_DIV=2, enable=1, tone_en=0.
- Strobe 0x24 ('E') -> fifo_level=1 one cycle after the strobe; morse_out high exactly 4 cycles, then low 12 cycles; busy falls in the following IDLE cycle.
- Strobe 0x1B ('S') -> three 4-cycle marks separated by 4-cycle lows, then a 12-cycle low. Strobe 0x2C ('T') -> a single 12-cycle mark.
- Strobes 0xF0, 0x24, then 0xE0, 0x24 -> the first 0x24 produces no entry and no mark; exactly one 'E' pulse follows from the second 0x24.
- Strobes 0x24, 0x29, 0x24 -> two 4-cycle marks with a 29-cycle low between them: 12 (char gap) + 1 (idle) + 16 (word gap).
- enable=0, then five strobes of 0x24 -> fifo_level=4, fifo_full=1, overflow=1. Then enable=1 -> exactly 4 pulses, level returns to 0, overflow stays 1 until rst_n is asserted.
- tone_en=1, strobe 0x2C -> tone_out toggles every 2 cycles during the 12-cycle mark and is 0 otherwise. Asserting rst_n low mid-mark -> morse_out, tone_out, busy and fifo_level go to 0 asynchronously.
